// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream, assembles
// big-endian 32-bit words and writes them out one per cycle, holding the CPU until done.
module imem_loader #(
    parameter int SIZE    = 1024,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_written,
    output logic               cpu_hold
);

    localparam int              IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [16:0]     SIZE_L    = 17'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_CHECK, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t              state;
    logic [15:0]         count;
    logic [1:0]          byte_idx;
    logic [INSTR_W-1:0]  asm_reg;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                accept;
    logic                timed_out;

    assign accept    = in_valid && in_ready;
    assign timed_out = (TIMEOUT != 0) && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            cpu_hold      <= 1'b1;
            count         <= '0;
            byte_idx      <= '0;
            asm_reg       <= '0;
            idle_cnt      <= '0;
        end else begin
            mem_we <= 1'b0;

            // in_ready is high exactly in the three byte-consuming states, so it
            // doubles as the enable for the inter-byte idle counter.
            if (in_ready) begin
                if (accept)
                    idle_cnt <= '0;
                else if (TIMEOUT != 0)
                    idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state         <= S_HDR_HI;
                        in_ready      <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_written <= '0;
                        cpu_hold      <= 1'b1;
                        idle_cnt      <= '0;
                    end
                end
                S_HDR_HI, S_HDR_LO, S_DATA: begin
                    if (accept) begin
                        if (state == S_HDR_HI) begin
                            count[15:8] <= in_data;
                            state       <= S_HDR_LO;
                        end else if (state == S_HDR_LO) begin
                            count[7:0] <= in_data;
                            state      <= S_CHECK;
                            in_ready   <= 1'b0;
                        end else begin
                            asm_reg  <= {asm_reg[INSTR_W-9:0], in_data};
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                // Write is issued straight from the final byte so the
                                // strobe lands in the cycle after the 4th accept.
                                state     <= S_WRITE;
                                in_ready  <= 1'b0;
                                mem_we    <= 1'b1;
                                mem_addr  <= ADDR_W'({words_written, 2'b00});
                                mem_wdata <= {asm_reg[INSTR_W-9:0], in_data};
                            end
                        end
                    end else if (timed_out) begin
                        state    <= S_ERROR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (count == 16'd0 || {1'b0, count} > SIZE_L) begin
                        state <= S_ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        state    <= S_DATA;
                        in_ready <= 1'b1;
                        byte_idx <= '0;
                    end
                end
                S_WRITE: begin
                    words_written <= words_written + 16'd1;
                    if ((words_written + 16'd1) == count) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= S_DATA;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes the instruction memory from a byte stream. It is the write side of the fetch-path instruction store.
- Accepts a length-prefixed byte stream over a valid/ready handshake and assembles 32-bit instructions, most-significant byte first.
- Issues one registered write per instruction to the memory's write port at byte address 4*index.
- Holds the CPU via cpu_hold until a complete, valid image is loaded.

Parameters:
- SIZE, 1024, instruction memory depth in words; the maximum legal word count.
- ADDR_W, 64, width of mem_addr; matches the datapath word width.
- INSTR_W, 32, instruction width; fixed at 4 bytes.
- TIMEOUT, 65535, maximum idle cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a (re)load.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_W  byte address of the write; always a multiple of 4.
- mem_wdata  output  INSTR_W  instruction to write.
- busy  output  1  load in progress.
- done  output  1  image fully loaded; sticky.
- error  output  1  load aborted; sticky.
- words_written  output  16  number of instructions written in the current load.
- cpu_hold  output  1  keeps the processor in reset.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - State IDLE.
  - cpu_hold=1; every other output 0; internal count and byte counters cleared.
  - Memory contents are not altered by reset. A partially assembled word is discarded.
- All outputs are registered. A byte is accepted on a rising edge with in_valid&&in_ready. in_ready is 1 only in HDR_HI, HDR_LO and DATA.
- Stream format: count[15:8], count[7:0], then count×4 instruction bytes, MSB first within each word.
- States and transitions:
  - IDLE: start → HDR_HI with busy=1, done=0, error=0, words_written=0, cpu_hold=1.
  - HDR_HI: on accept, count[15:8]=byte → HDR_LO.
  - HDR_LO: on accept, count[7:0]=byte → CHECK.
  - CHECK (one cycle, in_ready=0): if count==0 or count>SIZE → ERROR; else DATA with byte index 0.
  - DATA: each accept shifts the byte into the assembly register (shift = (reg<<8)|byte). After the 4th byte → WRITE.
  - WRITE (one cycle, in_ready=0): mem_we=1, mem_addr=words_written*4 zero-extended to ADDR_W, mem_wdata=assembled word. At the end of the cycle words_written increments. If the new value equals count → DONE; else → DATA.
  - DONE: done=1, busy=0, cpu_hold=0. Stays here until start.
  - ERROR: error=1, busy=0, cpu_hold=1. Stays here until start.
- Latency: the 4th byte accepted at edge N produces mem_we high for exactly the cycle after edge N. The next byte can be accepted no earlier than edge N+2.
- start while busy is ignored. start in DONE or ERROR restarts exactly as from IDLE: cpu_hold reasserts the same edge, and done/error clear. No memory erase occurs.
- in_valid in a non-ready state has no effect; the sender holds its byte.
- Timeout:
  - The idle counter counts cycles in HDR_HI, HDR_LO and DATA with no accept, and resets on each accept.
  - Reaching TIMEOUT → ERROR. Words already written remain in memory; words_written holds its value.
  - TIMEOUT=0 disables the counter.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- reset asserted mid-load forces IDLE immediately; the remainder of the stream is ignored until the next start.

Test Plan:
- Reset then idle: outputs cpu_hold=1, all others 0. in_valid=1 with no start → in_ready stays 0 and mem_we never fires.
- start, stream 00 02 F8 40 03 E0 D1 00 04 21:
  - writes (addr 0, F84003E0) and (addr 4, D1000421).
  - Each mem_we is exactly 1 cycle, one cycle after the 4th byte.
  - done=1, cpu_hold=0, words_written=2.
- Header 00 00 → error=1 two cycles after the 2nd byte, no mem_we. Header 04 01 (1025 > SIZE) → error=1, no mem_we.
- TIMEOUT=8, send header 00 01 and 2 data bytes, then stall 8 cycles → error=1, words_written=0, no mem_we.
- Reset pulse after the 5th data byte of a 3-word load: word 0 is already written, outputs return to reset values. A new start with a full 1-word image writes addr 0 and ends with done=1.
- start pulsed during DATA is ignored. start in DONE → cpu_hold=1 and done=0 on the same edge, in_ready=1 next cycle.
